regfile_write_port: RTL and testbench

//   Write side of the 32 x 32-bit register file: accepts one write per cycle,

---
 rtl/regfile_write_port.sv | 128 ++++++++++++
 tb/tb_regfile_write_port.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_port.sv
// Write side of a register file: a two-stage accept/commit pipeline into the bank,
// an in-flight write exposed for read-side bypass, and a sequenced bank-clear sweep.
module regfile_write_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           clr_start,
    output logic                           clr_done,
    output logic                           pend_valid,
    output logic [ADDR_WIDTH-1:0]          pend_addr,
    output logic [DATA_WIDTH-1:0]          pend_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   clr_idx;
    logic [ADDR_WIDTH-1:0]   next_idx;
    logic                    accept;
    logic                    clearing;

    logic                    vld_p1;
    logic [NUM_REGS-1:0]     onehot_p1;
    logic [ADDR_WIDTH-1:0]   addr_p1;
    logic [DATA_WIDTH-1:0]   data_p1;

    logic [DATA_WIDTH-1:0]   bank [1:NUM_REGS-1];

    // Register 0 never gets an enable, so writes to it are dropped at commit.
    function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [NUM_REGS-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        oh[0]    = 1'b0;
        return oh;
    endfunction

    assign accept   = wr_valid && wr_ready;
    assign clearing = (state == CLEAR);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state   <= next_state;
            clr_idx <= next_idx;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = clr_idx;
        wr_ready   = 1'b0;
        clr_done   = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (clr_start) begin
                    next_state = CLEAR;
                    next_idx   = ADDR_WIDTH'(1);
                end
            end
            CLEAR: begin
                next_idx = clr_idx + ADDR_WIDTH'(1);
                if (clr_idx == ADDR_WIDTH'(NUM_REGS - 1)) begin
                    next_state = IDLE;
                    clr_done   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Stage 1: capture the accepted write.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            onehot_p1 <= '0;
            addr_p1   <= '0;
            data_p1   <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                onehot_p1 <= decode(wr_addr);
                addr_p1   <= wr_addr;
                data_p1   <= wr_data;
            end
        end
    end

    assign pend_valid = vld_p1 && (addr_p1 != '0);
    assign pend_addr  = addr_p1;
    assign pend_data  = data_p1;

    // Stage 2: commit to the bank; the sweep's clear overrides a same-cycle commit.
    always_ff @(posedge clock) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (reset) begin
                bank[i] <= '0;
            end else if (clearing && (clr_idx == ADDR_WIDTH'(i))) begin
                bank[i] <= '0;
            end else if (vld_p1 && onehot_p1[i]) begin
                bank[i] <= data_p1;
            end
        end
    end

    always_comb begin
        reg_flat = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            reg_flat[i*DATA_WIDTH +: DATA_WIDTH] = bank[i];
        end
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: write latency, address-0 drop,
// back-to-back writes, bank-clear sweep, clear/write collision and reset abort.
module tb_regfile_write_port;

    logic          clock;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          clr_start;
    logic          clr_done;
    logic          pend_valid;
    logic [4:0]    pend_addr;
    logic [31:0]   pend_data;
    logic [1023:0] reg_flat;

    int n_vec = 0;
    int n_err = 0;

    regfile_write_port #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr_start  (clr_start),
        .clr_done   (clr_done),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data),
        .reg_flat   (reg_flat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rd(input int i);
        return reg_flat[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %0b want 1", wr_ready); end
        n_vec++; if (clr_done !== 1'b0) begin n_err++; $display("FAIL reset_clr_done got %0b want 0", clr_done); end
        n_vec++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL reset_pend_valid got %0b want 0", pend_valid); end
        n_vec++; if (pend_addr !== 5'd0) begin n_err++; $display("FAIL reset_pend_addr got %0d want 0", pend_addr); end
        n_vec++; if (pend_data !== 32'd0) begin n_err++; $display("FAIL reset_pend_data got %h want 0", pend_data); end
        for (int i = 0; i < 32; i++) begin
            n_vec++; if (rd(i) !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d got %h want 0", i, rd(i)); end
        end
    endtask

    task automatic test_write_latency();
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_valid = 1'b0;
        n_vec++; if (pend_valid !== 1'b1) begin n_err++; $display("FAIL w5_pend_valid got %0b want 1", pend_valid); end
        n_vec++; if (pend_addr !== 5'd5) begin n_err++; $display("FAIL w5_pend_addr got %0d want 5", pend_addr); end
        n_vec++; if (pend_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL w5_pend_data got %h want deadbeef", pend_data); end
        n_vec++; if (rd(5) !== 32'd0) begin n_err++; $display("FAIL w5_early got %h want 0", rd(5)); end
        tick();
        n_vec++; if (rd(5) !== 32'hDEADBEEF) begin n_err++; $display("FAIL w5_commit got %h want deadbeef", rd(5)); end
        n_vec++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL w5_pend_drain got %0b want 0", pend_valid); end
        for (int i = 0; i < 32; i++) begin
            if (i != 5) begin
                n_vec++; if (rd(i) !== 32'd0) begin n_err++; $display("FAIL w5_other_reg%0d got %h want 0", i, rd(i)); end
            end
        end
    endtask

    task automatic test_addr0();
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_valid = 1'b0;
        n_vec++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL a0_pend_valid got %0b want 0", pend_valid); end
        tick();
        n_vec++; if (rd(0) !== 32'd0) begin n_err++; $display("FAIL a0_reg0 got %h want 0", rd(0)); end
        n_vec++; if (rd(5) !== 32'hDEADBEEF) begin n_err++; $display("FAIL a0_reg5 got %h want deadbeef", rd(5)); end
    endtask

    task automatic test_back_to_back();
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
        tick();
        wr_data = 32'h2;
        n_vec++; if (pend_data !== 32'h1) begin n_err++; $display("FAIL b2b_pend1 got %h want 1", pend_data); end
        tick();
        wr_data = 32'h3;
        n_vec++; if (rd(7) !== 32'h1) begin n_err++; $display("FAIL b2b_reg7_1 got %h want 1", rd(7)); end
        n_vec++; if (pend_data !== 32'h2) begin n_err++; $display("FAIL b2b_pend2 got %h want 2", pend_data); end
        tick();
        wr_valid = 1'b0;
        n_vec++; if (rd(7) !== 32'h2) begin n_err++; $display("FAIL b2b_reg7_2 got %h want 2", rd(7)); end
        tick();
        n_vec++; if (rd(7) !== 32'h3) begin n_err++; $display("FAIL b2b_reg7_3 got %h want 3", rd(7)); end
        tick();
        n_vec++; if (rd(7) !== 32'h3) begin n_err++; $display("FAIL b2b_final got %h want 3", rd(7)); end
    endtask

    task automatic test_clear_sweep();
        int busy;
        int dones;
        for (int i = 1; i < 32; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            n_vec++; if (rd(i) !== 32'(i)) begin n_err++; $display("FAIL fill_reg%0d got %h want %h", i, rd(i), 32'(i)); end
        end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy  = 0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (wr_ready === 1'b0) busy++;
            if (clr_done === 1'b1) dones++;
            tick();
        end
        n_vec++; if (busy != 31) begin n_err++; $display("FAIL clr_busy_cycles got %0d want 31", busy); end
        n_vec++; if (dones != 1) begin n_err++; $display("FAIL clr_done_pulses got %0d want 1", dones); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL clr_ready_after got %0b want 1", wr_ready); end
        for (int i = 0; i < 32; i++) begin
            n_vec++; if (rd(i) !== 32'd0) begin n_err++; $display("FAIL clr_reg%0d got %h want 0", i, rd(i)); end
        end
    endtask

    task automatic test_write_with_clear();
        bit seen;
        wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 32'hAA; clr_start = 1'b1;
        tick();
        wr_valid = 1'b0; clr_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (clr_done === 1'b1) seen = 1'b1;
            tick();
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL wc_done got none want pulse within 50 cycles"); end
        n_vec++; if (rd(1) !== 32'd0) begin n_err++; $display("FAIL wc_reg1 got %h want 0", rd(1)); end
    endtask

    task automatic test_reset_mid_sweep();
        int dones;
        wr_valid = 1'b1; wr_addr = 5'd20; wr_data = 32'h1234;
        tick();
        wr_addr = 5'd31; wr_data = 32'h5678;
        tick();
        wr_valid = 1'b0;
        tick();
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        dones = 0;
        for (int k = 1; k < 10; k++) begin
            if (clr_done === 1'b1) dones++;
            tick();
        end
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rs_busy got %0b want 0", wr_ready); end
        n_vec++; if (rd(20) !== 32'h1234) begin n_err++; $display("FAIL rs_reg20_pre got %h want 1234", rd(20)); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rs_ready got %0b want 1", wr_ready); end
        for (int i = 0; i < 32; i++) begin
            n_vec++; if (rd(i) !== 32'd0) begin n_err++; $display("FAIL rs_reg%0d got %h want 0", i, rd(i)); end
        end
        for (int c = 0; c < 40; c++) begin
            if (clr_done === 1'b1) dones++;
            tick();
        end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL rs_clr_done got %0d pulses want 0", dones); end
        n_vec++; if (rd(31) !== 32'd0) begin n_err++; $display("FAIL rs_reg31_late got %h want 0", rd(31)); end
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0;
        test_reset();
        test_write_latency();
        test_addr0();
        test_back_to_back();
        test_clear_sweep();
        test_write_with_clear();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
